// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generation, a DEPTH-entry queue of {instr, pc+4}, and a valid/ready port to decode.
// Optional feature: define FETCH_BYPASS_EN to present a fetch to decode in the same cycle when the queue is empty.
module fetch_queue #(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        imem_en,
  output logic [XLEN-1:0]             imem_addr,
  input  logic [XLEN-1:0]             imem_rdata,
  input  logic                        redirect,
  input  logic [XLEN-1:0]             redirect_pc,
  output logic                        id_valid,
  input  logic                        id_ready,
  output logic [XLEN-1:0]             id_instr,
  output logic [XLEN-1:0]             id_pcplus4,
  output logic [$clog2(DEPTH):0]      fq_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pcp4_q  [DEPTH];

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_target;
  logic            queue_full;
  logic            head_valid;
  logic            deq;
  logic            enq;

  assign pc_plus4        = pc_q + XLEN'(4);
  // Masking keeps every redirect_pc bit in use while forcing word alignment.
  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign queue_full      = (count_q == CW'(DEPTH));
  assign head_valid      = (count_q != '0);

`ifdef FETCH_BYPASS_EN
  logic bypass;

  // With an empty queue the fetch cannot depend on a dequeue, so no loop through imem_en.
  assign bypass   = reset & ~redirect & ~head_valid;
  assign id_valid = (head_valid | bypass) & ~redirect;
  assign deq      = head_valid & id_valid & id_ready;
  assign imem_en  = reset & ~redirect & (~queue_full | deq);
  assign enq      = imem_en & ~(bypass & id_ready);

  always_comb begin
    id_instr   = '0;
    id_pcplus4 = '0;
    if (id_valid && head_valid) begin
      id_instr   = instr_q[rd_ptr_q];
      id_pcplus4 = pcp4_q[rd_ptr_q];
    end else if (id_valid) begin
      id_instr   = imem_rdata;
      id_pcplus4 = pc_plus4;
    end
  end
`else
  assign id_valid = head_valid & ~redirect;
  assign deq      = id_valid & id_ready;
  assign imem_en  = reset & ~redirect & (~queue_full | deq);
  assign enq      = imem_en;

  always_comb begin
    id_instr   = '0;
    id_pcplus4 = '0;
    if (id_valid) begin
      id_instr   = instr_q[rd_ptr_q];
      id_pcplus4 = pcp4_q[rd_ptr_q];
    end
  end
`endif

  assign imem_addr = pc_q;
  assign fq_count  = count_q;

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      pc_d     = redirect_target;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (imem_en) pc_d = pc_plus4;
      if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a redirect leaves stale data behind, which is harmless since count is zeroed.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic wr_hit;
      assign wr_hit = enq & ~redirect & (wr_ptr_q == AW'(gi));

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          instr_q[gi] <= '0;
          pcp4_q[gi]  <= '0;
        end else if (wr_hit) begin
          instr_q[gi] <= imem_rdata;
          pcp4_q[gi]  <= pc_plus4;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, no bypass): vector table plus stall, reset and PC-wrap sequences.
module tb_fetch_queue;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  typedef struct {
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pcp4;
    logic [2:0]  count;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pcplus4;
  logic [2:0]  fq_count;

  logic        reset_w = 1'b0;
  logic        imem_en_w;
  logic [31:0] imem_addr_w;
  logic [31:0] imem_rdata_w;
  logic        id_valid_w;
  logic [31:0] id_instr_w;
  logic [31:0] id_pcplus4_w;
  logic [2:0]  fq_count_w;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  // Instruction memory model: word derived from its address.
  assign imem_rdata   = imem_addr ^ KEY;
  assign imem_rdata_w = imem_addr_w ^ KEY;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pcplus4(id_pcplus4), .fq_count(fq_count)
  );

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clock(clock), .reset(reset_w), .imem_en(imem_en_w), .imem_addr(imem_addr_w),
    .imem_rdata(imem_rdata_w), .redirect(1'b0), .redirect_pc(32'h0),
    .id_valid(id_valid_w), .id_ready(1'b1), .id_instr(id_instr_w),
    .id_pcplus4(id_pcplus4_w), .fq_count(fq_count_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_main(input int idx, input vec_t v);
    logic [31:0] exp_instr;
    exp_instr = v.valid ? ((v.pcp4 - 32'd4) ^ KEY) : 32'h0;
    check($sformatf("v%0d.imem_en", idx),    {31'b0, imem_en},  {31'b0, v.en});
    check($sformatf("v%0d.imem_addr", idx),  imem_addr,         v.addr);
    check($sformatf("v%0d.id_valid", idx),   {31'b0, id_valid}, {31'b0, v.valid});
    check($sformatf("v%0d.id_pcplus4", idx), id_pcplus4,        v.pcp4);
    check($sformatf("v%0d.id_instr", idx),   id_instr,          exp_instr);
    check($sformatf("v%0d.fq_count", idx),   {29'b0, fq_count}, {29'b0, v.count});
    $display("[TB] cycle %0d redir=%0b rdy=%0b en=%0b addr=%h valid=%0b pcp4=%h cnt=%0d",
             idx, v.redirect, v.ready, imem_en, imem_addr, id_valid, id_pcplus4, fq_count);
  endtask

  vec_t vq[$];

  initial begin
    //           redir rpc           rdy  en   addr          vld  pcp4          cnt
    vq.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0}); // 0
    vq.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h04, 1'b1, 32'h04, 3'd1});
    vq.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h08, 1'b1, 32'h08, 3'd1});
    vq.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h0C, 1'b1, 32'h08, 3'd2});
    vq.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h10, 1'b1, 32'h08, 3'd3});
    vq.push_back('{1'b0, 32'h0,     1'b0, 1'b0, 32'h14, 1'b1, 32'h08, 3'd4}); // 5: full
    vq.push_back('{1'b0, 32'h0,     1'b0, 1'b0, 32'h14, 1'b1, 32'h08, 3'd4});
    vq.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h14, 1'b1, 32'h08, 3'd4}); // full + deq fetch
    vq.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h18, 1'b1, 32'h0C, 3'd4});
    vq.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 3'd4});
    vq.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h20, 1'b1, 32'h14, 3'd4}); // 10
    vq.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h24, 1'b1, 32'h18, 3'd4});
    vq.push_back('{1'b1, 32'h103,   1'b1, 1'b0, 32'h28, 1'b0, 32'h00, 3'd4}); // redirect
    vq.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h100, 1'b0, 32'h00, 3'd0});
    vq.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h104, 1'b1, 32'h104, 3'd1});
    vq.push_back('{1'b0, 32'h0,     1'b0, 1'b1, 32'h108, 1'b1, 32'h104, 3'd2}); // 15
    vq.push_back('{1'b1, 32'h200,   1'b1, 1'b0, 32'h10C, 1'b0, 32'h00, 3'd3}); // redirect w/ ready
    vq.push_back('{1'b1, 32'h302,   1'b1, 1'b0, 32'h200, 1'b0, 32'h00, 3'd0}); // back-to-back
    vq.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h300, 1'b0, 32'h00, 3'd0});
    vq.push_back('{1'b0, 32'h0,     1'b1, 1'b1, 32'h304, 1'b1, 32'h304, 3'd1});

    // Reset state while held in reset.
    #12;
    check("rst.imem_en",   {31'b0, imem_en},  32'h0);
    check("rst.imem_addr", imem_addr,         32'h0);
    check("rst.id_valid",  {31'b0, id_valid}, 32'h0);
    check("rst.id_instr",  id_instr,          32'h0);
    check("rst.id_pcp4",   id_pcplus4,        32'h0);
    check("rst.fq_count",  {29'b0, fq_count}, 32'h0);

    @(posedge clock); #1;
    reset = 1'b1;

    foreach (vq[i]) begin
      redirect    = vq[i].redirect;
      redirect_pc = vq[i].rpc;
      id_ready    = vq[i].ready;
      @(negedge clock);
      check_main(i, vq[i]);
      @(posedge clock); #1;
    end

    // Stall until full, then pull reset mid-cycle.
    redirect = 1'b0;
    id_ready = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("fill.fq_count", {29'b0, fq_count}, 32'd4);
    check("fill.imem_en",  {31'b0, imem_en},  32'h0);
    #2 reset = 1'b0;
    #1;
    check("async.id_valid", {31'b0, id_valid}, 32'h0);
    check("async.fq_count", {29'b0, fq_count}, 32'h0);
    check("async.id_instr", id_instr,          32'h0);
    check("async.imem_en",  {31'b0, imem_en},  32'h0);
    check("async.imem_addr", imem_addr,        32'h0);
    $display("[TB] mid-run reset: valid=%0b cnt=%0d addr=%h", id_valid, fq_count, imem_addr);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    check("resume.imem_en",   {31'b0, imem_en},  32'h1);
    check("resume.imem_addr", imem_addr,         32'h0);
    @(posedge clock); #1;
    @(negedge clock);
    check("resume.id_pcp4",   id_pcplus4,        32'h4);
    check("resume.id_instr",  id_instr,          32'h0 ^ KEY);

    // PC wrap on the second instance.
    @(posedge clock); #1;
    reset_w = 1'b1;
    @(negedge clock);
    check("wrap.addr0", imem_addr_w, 32'hFFFF_FFF8);
    check("wrap.vld0",  {31'b0, id_valid_w}, 32'h0);
    @(posedge clock); #1; @(negedge clock);
    check("wrap.addr1", imem_addr_w,  32'hFFFF_FFFC);
    check("wrap.pcp4_1", id_pcplus4_w, 32'hFFFF_FFFC);
    @(posedge clock); #1; @(negedge clock);
    check("wrap.addr2", imem_addr_w,  32'h0000_0000);
    check("wrap.pcp4_2", id_pcplus4_w, 32'h0000_0000);
    @(posedge clock); #1; @(negedge clock);
    check("wrap.pcp4_3", id_pcplus4_w, 32'h0000_0004);
    check("wrap.instr3", id_instr_w,   32'h0000_0000 ^ KEY);
    $display("[TB] pc wrap: addr=%h pcp4=%h", imem_addr_w, id_pcplus4_w);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
